// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - shared types and defaults for the pedestrian push-button block
package semaforo_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        ATENDIDO = 2'd2,
        BLOQUEIO = 2'd3
    } estado_t;

    localparam int DEB_CICLOS_PADRAO  = 4;
    localparam int BLOQ_CICLOS_PADRAO = 2;

endpackage

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - two-flop synchronizer plus level debouncer for a raw push-button
module debounce_botao
    import semaforo_pkg::*;
#(
    parameter int DEB_CICLOS = DEB_CICLOS_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic bruto,
    output logic estavel
);

    localparam int             CW      = $clog2(DEB_CICLOS) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CICLOS - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // A new level is accepted only after DEB_CICLOS consecutive differing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            estavel <= 1'b0;
            cnt     <= '0;
        end else begin
            s1 <= bruto;
            s2 <= s1;
            if (s2 != estavel) begin
                if (cnt == CNT_MAX) begin
                    estavel <= s2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/botoeira_pedestre.sv
// rtl/botoeira_pedestre.sv - pedestrian push-button box: request FSM, wait lamp and lamp-fault flag
module botoeira_pedestre
    import semaforo_pkg::*;
#(
    parameter int DEB_CICLOS  = DEB_CICLOS_PADRAO,
    parameter int BLOQ_CICLOS = BLOQ_CICLOS_PADRAO
) (
    input  logic clk,
    input  logic reset,
    input  logic botao_bruto,
    input  logic Q4,
    input  logic Q5,
    output logic botao_pedestre,
    output logic aguarde,
    output logic erro_lampada
);

    localparam int            BW         = $clog2(BLOQ_CICLOS) + 1;
    localparam logic [BW-1:0] BLOQ_CARGA = BW'(BLOQ_CICLOS - 1);

    logic          estavel;
    logic          estavel_d;
    logic          pressao;
    logic          igual_d;
    estado_t       estado;
    estado_t       prox_estado;
    logic [BW-1:0] cnt_bloq;
    logic [BW-1:0] prox_cnt_bloq;

    debounce_botao #(
        .DEB_CICLOS(DEB_CICLOS)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .bruto  (botao_bruto),
        .estavel(estavel)
    );

    assign pressao = estavel & ~estavel_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estavel_d    <= 1'b0;
            estado       <= OCIOSO;
            cnt_bloq     <= '0;
            igual_d      <= 1'b0;
            erro_lampada <= 1'b0;
        end else begin
            estavel_d <= estavel;
            estado    <= prox_estado;
            cnt_bloq  <= prox_cnt_bloq;
            igual_d   <= (Q4 == Q5);
            // Both lamps equal on two consecutive edges is a real fault, not a switching glitch.
            if (igual_d && (Q4 == Q5)) begin
                erro_lampada <= 1'b1;
            end
        end
    end

    always_comb begin
        prox_estado   = estado;
        prox_cnt_bloq = cnt_bloq;
        case (estado)
            OCIOSO: begin
                if (pressao && !Q5) begin
                    prox_estado = ESPERA;
                end
            end
            ESPERA: begin
                if (Q5) begin
                    prox_estado = ATENDIDO;
                end
            end
            ATENDIDO: begin
                if (!Q5) begin
                    prox_estado   = BLOQUEIO;
                    prox_cnt_bloq = BLOQ_CARGA;
                end
            end
            BLOQUEIO: begin
                if (cnt_bloq == '0) begin
                    prox_estado = OCIOSO;
                end else begin
                    prox_cnt_bloq = cnt_bloq - 1'b1;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    assign botao_pedestre = (estado == ESPERA);
    assign aguarde        = (estado == ESPERA);

endmodule

// File: tb/tb_botoeira_pedestre.sv
// tb/tb_botoeira_pedestre.sv - directed self-checking bench for botoeira_pedestre
module tb_botoeira_pedestre;

    logic clk         = 1'b0;
    logic reset       = 1'b1;
    logic botao_bruto = 1'b0;
    logic Q4          = 1'b1;
    logic Q5          = 1'b0;
    logic botao_pedestre;
    logic aguarde;
    logic erro_lampada;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    botoeira_pedestre #(
        .DEB_CICLOS (4),
        .BLOQ_CICLOS(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .botao_bruto   (botao_bruto),
        .Q4            (Q4),
        .Q5            (Q5),
        .botao_pedestre(botao_pedestre),
        .aguarde       (aguarde),
        .erro_lampada  (erro_lampada)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic exp);
        check({tag, "_req"}, botao_pedestre, exp);
        check({tag, "_wait"}, aguarde, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] bounce_pat;

    initial begin
        bounce_pat = 8'b0111_0111;

        #2 reset = 1'b0;
        tick(2);
        check_req("reset", 1'b0);
        check("reset_err", erro_lampada, 1'b0);
        reset = 1'b1;
        tick(2);

        // lamp fault: single-cycle equality is tolerated, two cycles latch
        Q4 = 1'b1; Q5 = 1'b1;
        tick(1);
        Q4 = 1'b1; Q5 = 1'b0;
        tick(1);
        check("glitch_err", erro_lampada, 1'b0);
        tick(2);
        check("glitch_err_late", erro_lampada, 1'b0);
        Q4 = 1'b0; Q5 = 1'b0;
        tick(1);
        check("fault_1cyc", erro_lampada, 1'b0);
        tick(1);
        check("fault_2cyc", erro_lampada, 1'b1);
        Q4 = 1'b1; Q5 = 1'b0;
        tick(3);
        check("fault_sticky", erro_lampada, 1'b1);
        check_req("fault_idle", 1'b0);

        // clean press: request from edge 7 onward
        botao_bruto = 1'b1;
        tick(6);
        check_req("clean_e6", 1'b0);
        tick(1);
        check_req("clean_e7", 1'b1);
        tick(5);
        check_req("clean_e12", 1'b1);
        botao_bruto = 1'b0;

        // service
        Q4 = 1'b0; Q5 = 1'b1;
        tick(1);
        check_req("served", 1'b0);
        check("served_err", erro_lampada, 1'b1);
        tick(8);
        botao_bruto = 1'b1;
        tick(10);
        check_req("press_in_green", 1'b0);
        botao_bruto = 1'b0;
        tick(8);

        // press event lands on the first blocked edge after Q5 falls
        botao_bruto = 1'b1;
        tick(5);
        Q4 = 1'b1; Q5 = 1'b0;
        tick(1);
        check_req("block_e6", 1'b0);
        tick(1);
        check_req("block_e7", 1'b0);
        tick(1);
        check_req("block_e8", 1'b0);
        tick(4);
        check_req("block_after", 1'b0);
        botao_bruto = 1'b0;
        tick(8);
        botao_bruto = 1'b1;
        tick(6);
        check_req("post_block_e6", 1'b0);
        tick(1);
        check_req("post_block_e7", 1'b1);

        // reset mid-request with button held
        #3 reset = 1'b0;
        #1;
        check_req("async_reset", 1'b0);
        check("async_reset_err", erro_lampada, 1'b0);
        tick(2);
        check_req("in_reset", 1'b0);
        reset = 1'b1;
        tick(6);
        check_req("rel_e6", 1'b0);
        tick(1);
        check_req("rel_e7", 1'b1);

        // serve and drain back to idle
        botao_bruto = 1'b0;
        Q4 = 1'b0; Q5 = 1'b1;
        tick(1);
        check_req("serve2", 1'b0);
        Q4 = 1'b1; Q5 = 1'b0;
        tick(10);
        check_req("idle2", 1'b0);

        // bounce 1,1,1,0,1,1,1,0 then held high
        for (int i = 0; i < 8; i++) begin
            botao_bruto = bounce_pat[i];
            tick(1);
            check_req("bounce", 1'b0);
        end
        botao_bruto = 1'b1;
        tick(6);
        check_req("bounce_e6", 1'b0);
        tick(1);
        check_req("bounce_e7", 1'b1);
        check("bounce_err", erro_lampada, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
